// File: rtl/seg7_scan_mux_pkg.sv
// Shared definitions for the seg7_scan_mux display scanner: FSM states and
// default geometry/timing parameters.
package seg7_scan_mux_pkg;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } scan_state_t;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_CLK_DIV    = 50000;
  localparam int DEF_DIV_W      = 16;

endpackage

// File: rtl/seg7_scan_mux_prescaler.sv
// Digit-slot prescaler: counts CLK_DIV clocks per slot and flags the last
// cycle of each slot with tick.
module seg7_scan_mux_prescaler
  import seg7_scan_mux_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DIV_W   = DEF_DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered data.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits.
module seg7_scan_mux
  import seg7_scan_mux_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DIV_W      = DEF_DIV_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    load,
  input  logic                    blank,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int                   IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;

  scan_state_t             state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [4*NUM_DIGITS-1:0] active, active_n;
  logic [4*NUM_DIGITS-1:0] pend, pend_n;
  logic                    pend_valid, pend_valid_n;
  logic                    started, started_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [3:0]              nibble_n;
  logic                    frame_start_n;
  logic                    tick;
  logic                    boundary;
  logic                    lead_zero;

  // Prescaler is held for the single post-reset gap so the first slot is full length.
  seg7_scan_mux_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (started),
    .tick (tick)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lead_zero = (idx != '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && active[4*k +: 4] != 4'h0) begin
        lead_zero = 1'b0;
      end
    end
  end
`else
  assign lead_zero = 1'b0;
`endif

  assign boundary = (state == ST_ON) && tick && (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_GAP;
      idx         <= '0;
      active      <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      started     <= 1'b0;
      an          <= AN_OFF;
      nibble_out  <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      active      <= active_n;
      pend        <= pend_n;
      pend_valid  <= pend_valid_n;
      started     <= started_n;
      an          <= an_n;
      nibble_out  <= nibble_n;
      frame_start <= frame_start_n;
    end
  end

  // A load landing exactly on the frame boundary bypasses the pending buffer.
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    active_n      = active;
    pend_n        = pend;
    pend_valid_n  = pend_valid;
    started_n     = started;
    an_n          = an;
    nibble_n      = nibble_out;
    frame_start_n = 1'b0;

    if (load) begin
      pend_n       = data_in;
      pend_valid_n = 1'b1;
    end

    if (boundary) begin
      if (load) begin
        active_n     = data_in;
        pend_valid_n = 1'b0;
      end else if (pend_valid) begin
        active_n     = pend;
        pend_valid_n = 1'b0;
      end
    end

    case (state)
      ST_GAP: begin
        if (!started) begin
          started_n     = 1'b1;
          frame_start_n = (idx == '0);
        end else begin
          state_n  = ST_ON;
          nibble_n = active[{idx, 2'b00} +: 4];
          an_n     = (blank || lead_zero) ? AN_OFF
                                          : ~(NUM_DIGITS'(1) << idx);
        end
      end
      ST_ON: begin
        if (tick) begin
          state_n       = ST_GAP;
          an_n          = AN_OFF;
          idx_n         = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          frame_start_n = (idx == IDX_LAST);
        end
      end
      default: begin
        state_n = ST_GAP;
        an_n    = AN_OFF;
      end
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux (4 digits, 4 clocks per slot).
// Frame phase p = edges since reset release mod 16; p=1 is the digit-0 gap.
module tb_seg7_scan_mux;

  logic        clk;
  logic        rst;
  logic        load;
  logic        blank;
  logic [15:0] data_in;
  logic [3:0]  nibble_out;
  logic [3:0]  an;
  logic        frame_start;

  int tests;
  int fails;
  int cyc;

  typedef struct {
    logic [15:0] pre;
    logic        has_pre;
    logic [15:0] data;
    logic        on_bnd;
    logic        blank;
    logic [15:0] exp_an;
    logic [15:0] exp_nib;
  } vec_t;

  vec_t        tbl [6];
  string       names [6];
  logic [15:0] prev_an;
  logic [15:0] prev_nib;

  seg7_scan_mux #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .DIV_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .load        (load),
    .blank       (blank),
    .nibble_out  (nibble_out),
    .an          (an),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic stepClk();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic l, input logic [15:0] d, input logic b);
    load    = l;
    data_in = d;
    blank   = b;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Walks one full frame (p=1..0) comparing every lit and gap cycle.
  task automatic checkNextFrame(input string tag, input logic [15:0] ean, input logic [15:0] enib);
    int p, q, slot;
    for (int n = 1; n <= 16; n++) begin
      stepClk();
      load = 1'b0;
      p    = cyc % 16;
      q    = (p + 15) % 16;
      slot = q / 4;
      if (q % 4 == 0) begin
        checkOutput($sformatf("%s_gap%0d_an", tag, slot), 16'(an), 16'hF);
        checkOutput($sformatf("%s_gap%0d_fs", tag, slot), 16'(frame_start),
                    (slot == 0) ? 16'h1 : 16'h0);
      end else begin
        checkOutput($sformatf("%s_d%0d_p%0d_an", tag, slot, p), 16'(an), 16'(ean[4*slot +: 4]));
        checkOutput($sformatf("%s_d%0d_p%0d_nib", tag, slot, p), 16'(nibble_out), 16'(enib[4*slot +: 4]));
        checkOutput($sformatf("%s_d%0d_p%0d_fs", tag, slot, p), 16'(frame_start), 16'h0);
      end
    end
  endtask

  initial begin
    int p, q, slot;
    tests = 0;
    fails = 0;
    cyc   = 0;

    tbl[0] = '{16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h7BDE, 16'h1234};
    tbl[1] = '{16'h0000, 1'b0, 16'hABCD, 1'b1, 1'b0, 16'h7BDE, 16'hABCD};
    tbl[2] = '{16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h7BDE, 16'h2222};
`ifdef LEADING_ZERO_BLANK_EN
    tbl[3] = '{16'h0000, 1'b0, 16'h0070, 1'b0, 1'b0, 16'hFFDE, 16'h0070};
    tbl[4] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFE, 16'h0000};
`else
    tbl[3] = '{16'h0000, 1'b0, 16'h0070, 1'b0, 1'b0, 16'h7BDE, 16'h0070};
    tbl[4] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h7BDE, 16'h0000};
`endif
    tbl[5] = '{16'h0000, 1'b0, 16'hF00F, 1'b0, 1'b1, 16'hFFFF, 16'hF00F};
    names[0] = "load_mid_1234";
    names[1] = "load_bnd_abcd";
    names[2] = "last_load_wins";
    names[3] = "value_0070";
    names[4] = "value_0000";
    names[5] = "blank_f00f";

    applyStimulus(1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_an", 16'(an), 16'hF);
    checkOutput("reset_nib", 16'(nibble_out), 16'h0);
    checkOutput("reset_fs", 16'(frame_start), 16'h0);

    rst = 1'b0;
    cyc = 0;
    checkNextFrame("after_reset", 16'h7BDE, 16'h0000);
    prev_an  = 16'h7BDE;
    prev_nib = 16'h0000;

    // Each vector: loads during frame F (old value must persist), new value in F+1.
    for (int i = 0; i < 6; i++) begin
      for (int n = 1; n <= 16; n++) begin
        stepClk();
        p    = cyc % 16;
        q    = (p + 15) % 16;
        slot = q / 4;
        if (slot >= 2 && q % 4 != 0) begin
          checkOutput($sformatf("%s_old_d%0d_p%0d_an", names[i], slot, p), 16'(an), 16'(prev_an[4*slot +: 4]));
          checkOutput($sformatf("%s_old_d%0d_p%0d_nib", names[i], slot, p), 16'(nibble_out), 16'(prev_nib[4*slot +: 4]));
        end
        load = 1'b0;
        if (tbl[i].has_pre && p == 6) begin
          load    = 1'b1;
          data_in = tbl[i].pre;
        end
        if (!tbl[i].on_bnd && p == 10) begin
          load    = 1'b1;
          data_in = tbl[i].data;
        end
        if (tbl[i].on_bnd && p == 0) begin
          load    = 1'b1;
          data_in = tbl[i].data;
        end
        if (p == 14) blank = tbl[i].blank;
      end
      checkNextFrame(names[i], tbl[i].exp_an, tbl[i].exp_nib);
      prev_an  = tbl[i].exp_an;
      prev_nib = tbl[i].exp_nib;
    end

    // Blank released mid-slot: current slot stays dark, next slot lights.
    for (int n = 1; n <= 10; n++) begin
      stepClk();
      p = cyc % 16;
      if (p == 1) checkOutput("blank_fs", 16'(frame_start), 16'h1);
      if (p <= 9) begin
        checkOutput($sformatf("blank_hold_p%0d_an", p), 16'(an), 16'hF);
      end else begin
        checkOutput("unblank_an", 16'(an), 16'hB);
        checkOutput("unblank_nib", 16'(nibble_out), 16'h0);
      end
      if (p == 6) blank = 1'b0;
    end

    // Pending load then asynchronous reset mid-slot: load must be discarded.
    load    = 1'b1;
    data_in = 16'h5555;
    stepClk();
    load = 1'b0;
    repeat (4) stepClk();
    #2 rst = 1'b1;
    #1;
    checkOutput("midscan_rst_an", 16'(an), 16'hF);
    checkOutput("midscan_rst_nib", 16'(nibble_out), 16'h0);
    checkOutput("midscan_rst_fs", 16'(frame_start), 16'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    checkNextFrame("post_rst_f1", 16'h7BDE, 16'h0000);
    checkNextFrame("post_rst_f2", 16'h7BDE, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
